// File: rtl/phase_marker_emitter.sv
// phase_marker_emitter: queues phase-marker event codes and merges them as slti markers into a fetch stream.
// Define MARKER_TRACE_EN to print EMIT_<NAME> for every marker accepted downstream.
module phase_marker_emitter #(
  parameter int EVT_DEPTH = 4,
  parameter int INST_W    = 32,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              evt_valid,
  input  logic [3:0]        evt_code,
  output logic              evt_ready,
  input  logic              in_valid,
  input  logic [INST_W-1:0] in_inst,
  output logic              in_ready,
  output logic              out_valid,
  output logic [INST_W-1:0] out_inst,
  output logic              out_is_mark,
  input  logic              out_ready,
  output logic              done,
  output logic [CNT_W-1:0]  mark_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);
  localparam int AW = $clog2(EVT_DEPTH);
  localparam logic [3:0] SIM_EXIT = 4'd14;
  typedef enum logic [1:0] {EMPTY, PASS, MARK, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] fifo [EVT_DEPTH];
  logic [AW:0] wptr, rptr;
  logic [3:0] code_r, head;
  logic full, empty, push, drop, accept, fin, free, load_mark, load_pass;
  assign head = fifo[rptr[AW-1:0]];
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign out_valid = (state == PASS) || (state == MARK);
  assign out_is_mark = state == MARK;
  assign done = state == DONE;
  assign accept = out_valid && out_ready;
  // the SIM_EXIT handshake retires the stage for good, so nothing may reload behind it
  assign fin = out_is_mark && out_ready && (code_r == SIM_EXIT);
  assign free = ((state == EMPTY) || accept) && !fin;
  assign load_mark = free && !empty;
  assign load_pass = free && empty && in_valid;
  assign in_ready = reset_n && load_pass;
  assign evt_ready = reset_n && !full && !done;
  assign push = evt_valid && evt_ready && (evt_code != 4'hf);
  assign drop = evt_valid && evt_ready && (evt_code == 4'hf);
  always_comb state_nx = fin ? DONE : load_mark ? MARK : load_pass ? PASS : free ? EMPTY : state;
  always_ff @(posedge clock)
    if (push) fifo[wptr[AW-1:0]] <= evt_code;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state    <= EMPTY;
      wptr     <= '0;
      rptr     <= '0;
      code_r   <= '0;
      out_inst <= '0;
      mark_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nx;
      if (push) wptr <= wptr + (AW+1)'(1);
      if (load_mark) begin
        rptr     <= rptr + (AW+1)'(1);
        code_r   <= head;
        out_inst <= INST_W'({8'h00, head, 20'h02013});
      end else if (load_pass) out_inst <= in_inst;
      if (accept && out_is_mark && !(&mark_cnt)) mark_cnt <= mark_cnt + CNT_W'(1);
      if (drop && !(&drop_cnt)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
`ifdef MARKER_TRACE_EN
  function automatic string mark_name(input logic [3:0] c);
    case (c)
      4'd0:    return "VCTM_START";
      4'd1:    return "VCTM_END";
      4'd2:    return "DELAY_START";
      4'd3:    return "DELAY_END";
      4'd4:    return "TEXE_START";
      4'd5:    return "TEXE_END";
      4'd6:    return "LEAK_START";
      4'd7:    return "LEAK_END";
      4'd8:    return "INIT_START";
      4'd9:    return "INIT_END";
      4'd10:   return "BIM_START";
      4'd11:   return "BIM_END";
      4'd12:   return "TRAIN_START";
      4'd13:   return "TRAIN_END";
      4'd14:   return "SIM_EXIT";
      default: return "ILLEGAL";
    endcase
  endfunction
  always_ff @(posedge clock)
    if (reset_n && accept && out_is_mark) $display("%t EMIT_%s", $time, mark_name(code_r));
`endif
endmodule
